// File: rtl/arb_weighted_rr.sv
// Weighted round-robin arbiter: each requester owns the grant for up to its
// programmed weight in consecutive cycles, then ownership rotates circularly.
module arb_weighted_rr #(
  parameter int REQ_NUM   = 4,
  parameter int WEIGHT_W  = 4,
  parameter int COUNTER_W = $clog2(REQ_NUM)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [REQ_NUM-1:0]   req,
  input  logic                 cfg_we,
  input  logic [COUNTER_W-1:0] cfg_idx,
  input  logic [WEIGHT_W-1:0]  cfg_weight,
  output logic [REQ_NUM-1:0]   grant,
  output logic [COUNTER_W-1:0] grant_id,
  output logic                 grant_valid,
  output logic                 dbg_state_o,
  output logic [COUNTER_W-1:0] dbg_ptr_o
);

  typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_e;

  state_e                state_q, state_d;
  logic [REQ_NUM-1:0]    grant_q, grant_d;
  logic [COUNTER_W-1:0]  grant_id_q, grant_id_d;
  logic [COUNTER_W-1:0]  ptr_q, ptr_d;
  logic [WEIGHT_W-1:0]   tcnt_q, tcnt_d;
  logic [WEIGHT_W-1:0]   tlim_q, tlim_d;
  logic [WEIGHT_W-1:0]   weight_q [REQ_NUM];

  logic [REQ_NUM-1:0]    elig;
  logic [COUNTER_W-1:0]  nxt_owner;
  logic [COUNTER_W-1:0]  scan_start;
  logic [2*REQ_NUM-1:0]  elig_rot;
  logic                  win_found;
  logic [COUNTER_W-1:0]  win_idx;
  logic [REQ_NUM-1:0]    win_oh;
  logic [WEIGHT_W-1:0]   win_weight;
  logic                  release_now;

  always_comb begin
    for (int i = 0; i < REQ_NUM; i++) begin
      elig[i] = req[i] && (weight_q[i] != '0);
    end
  end

  assign nxt_owner   = (int'(grant_id_q) == REQ_NUM - 1) ? '0 : grant_id_q + COUNTER_W'(1);
  // grant_q is one-hot while busy, so this picks out the owner's request bit.
  assign release_now = !(|(req & grant_q)) || (tcnt_q == tlim_q);
  assign scan_start  = (state_q == ST_BUSY) ? nxt_owner : ptr_q;

  // Rotate the doubled eligibility vector so bit 0 is the scan start.
  always_comb begin
    int j;
    j          = 0;
    elig_rot   = {elig, elig} >> scan_start;
    win_found  = 1'b0;
    win_idx    = '0;
    for (int i = 0; i < REQ_NUM; i++) begin
      if (!win_found && elig_rot[i]) begin
        win_found = 1'b1;
        j = int'(scan_start) + i;
        if (j >= REQ_NUM) j = j - REQ_NUM;
        win_idx = COUNTER_W'(j);
      end
    end
  end

  always_comb begin
    win_oh     = '0;
    win_weight = '0;
    for (int i = 0; i < REQ_NUM; i++) begin
      if (win_found && (COUNTER_W'(i) == win_idx)) begin
        win_oh[i]  = 1'b1;
        win_weight = weight_q[i];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    grant_id_d = grant_id_q;
    ptr_d      = ptr_q;
    tcnt_d     = tcnt_q;
    tlim_d     = tlim_q;
    case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          state_d    = ST_BUSY;
          grant_d    = win_oh;
          grant_id_d = win_idx;
          tlim_d     = win_weight;
          tcnt_d     = WEIGHT_W'(1);
        end
      end
      ST_BUSY: begin
        if (!release_now) begin
          tcnt_d = tcnt_q + WEIGHT_W'(1);
        end else begin
          ptr_d = nxt_owner;
          if (win_found) begin
            grant_d    = win_oh;
            grant_id_d = win_idx;
            tlim_d     = win_weight;
            tcnt_d     = WEIGHT_W'(1);
          end else begin
            state_d    = ST_IDLE;
            grant_d    = '0;
            grant_id_d = '0;
            tcnt_d     = '0;
            tlim_d     = '0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      grant_q    <= '0;
      grant_id_q <= '0;
      ptr_q      <= '0;
      tcnt_q     <= '0;
      tlim_q     <= '0;
      for (int i = 0; i < REQ_NUM; i++) weight_q[i] <= WEIGHT_W'(1);
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      grant_id_q <= grant_id_d;
      ptr_q      <= ptr_d;
      tcnt_q     <= tcnt_d;
      tlim_q     <= tlim_d;
      // Out-of-range indices match no entry and are dropped.
      for (int i = 0; i < REQ_NUM; i++) begin
        if (cfg_we && (cfg_idx == COUNTER_W'(i))) weight_q[i] <= cfg_weight;
      end
    end
  end

  assign grant       = grant_q;
  assign grant_id    = grant_id_q;
  assign grant_valid = (state_q == ST_BUSY);
  assign dbg_state_o = state_q;
  assign dbg_ptr_o   = ptr_q;

endmodule
